// File: rtl/uart_pkg.sv
// Shared definitions for the UART/ALU glue logic: default word widths and
// the sequencing controller's state encoding.
package uart_pkg;

  localparam int DBIT_DEF  = 8;
  localparam int NB_OP_DEF = 6;

  localparam logic [2:0] ST_WAIT_A  = 3'd0;
  localparam logic [2:0] ST_WAIT_B  = 3'd1;
  localparam logic [2:0] ST_WAIT_OP = 3'd2;
  localparam logic [2:0] ST_EXEC    = 3'd3;
  localparam logic [2:0] ST_SEND    = 3'd4;
  localparam logic [2:0] ST_WAIT_TX = 3'd5;

  typedef enum logic [2:0] {
    WAIT_A  = ST_WAIT_A,
    WAIT_B  = ST_WAIT_B,
    WAIT_OP = ST_WAIT_OP,
    EXEC    = ST_EXEC,
    SEND    = ST_SEND,
    WAIT_TX = ST_WAIT_TX
  } state_t;

endpackage

// File: rtl/uart_timeout_cnt.sv
// Inter-byte timeout counter: clears on clr, counts while en, and flags the
// terminal count combinationally so the controller can abort in that cycle.
module uart_timeout_cnt #(
  parameter int TO_W    = 20,
  parameter int TIMEOUT = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + TO_W'(1);
    end
  end

  assign expire = en && (cnt == LAST);

endmodule

// File: rtl/uart_alu_ctrl.sv
// Sequencing controller: collects A, B and opcode bytes from the UART
// receiver, runs them through the external ALU and hands the result to the TX.
module uart_alu_ctrl
  import uart_pkg::*;
#(
  parameter int DBIT    = DBIT_DEF,
  parameter int NB_OP   = NB_OP_DEF,
  parameter int TO_W    = 20,
  parameter int TIMEOUT = 1000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_done_tick,
  input  logic [DBIT-1:0]  rx_data,
  input  logic             tx_done_tick,
  input  logic [DBIT-1:0]  alu_result,
  output logic [DBIT-1:0]  alu_a,
  output logic [DBIT-1:0]  alu_b,
  output logic [NB_OP-1:0] alu_op,
  output logic [DBIT-1:0]  tx_data,
  output logic             tx_start,
  output logic             busy,
  output logic             err_timeout,
  output logic [2:0]       dbg_state
);

  // Handshake: rx_done_tick and tx_done_tick are single-cycle pulses that are
  // consumed only in the state waiting for them and otherwise dropped (no
  // buffering); tx_start is a single-cycle request, one per completed frame.

  state_t state, state_n;
  logic   ld_a, ld_b, ld_op, ld_tx;
  logic   cnt_clr, cnt_en, expire;

  uart_timeout_cnt #(
    .TO_W    (TO_W),
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .expire (expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= WAIT_A;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_op  <= '0;
      tx_data <= '0;
    end else begin
      state <= state_n;
      if (ld_a)  alu_a   <= rx_data;
      if (ld_b)  alu_b   <= rx_data;
      if (ld_op) alu_op  <= rx_data[NB_OP-1:0];
      if (ld_tx) tx_data <= alu_result;
    end
  end

  always_comb begin
    state_n = state;
    ld_a    = 1'b0;
    ld_b    = 1'b0;
    ld_op   = 1'b0;
    ld_tx   = 1'b0;
    cnt_clr = 1'b0;
    case (state)
      WAIT_A: begin
        if (rx_done_tick) begin
          ld_a    = 1'b1;
          cnt_clr = 1'b1;
          state_n = WAIT_B;
        end
      end
      WAIT_B: begin
        // A byte on the terminal-count cycle wins over the timeout.
        if (rx_done_tick) begin
          ld_b    = 1'b1;
          cnt_clr = 1'b1;
          state_n = WAIT_OP;
        end else if (expire) begin
          state_n = WAIT_A;
        end
      end
      WAIT_OP: begin
        if (rx_done_tick) begin
          ld_op   = 1'b1;
          state_n = EXEC;
        end else if (expire) begin
          state_n = WAIT_A;
        end
      end
      EXEC: begin
        ld_tx   = 1'b1;
        state_n = SEND;
      end
      SEND:    state_n = WAIT_TX;
      WAIT_TX: if (tx_done_tick) state_n = WAIT_A;
      default: state_n = WAIT_A;
    endcase
  end

  assign cnt_en      = (state == WAIT_B) || (state == WAIT_OP);
  assign err_timeout = expire && !rx_done_tick;
  assign tx_start    = (state == SEND);
  assign busy        = (state != WAIT_A);
  assign dbg_state   = state;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Directed bench for uart_alu_ctrl with a stand-in ALU; a scoreboard queue
// holds the expected {a, b, op, result} for every frame that should complete.
module tb_uart_alu_ctrl;

  localparam int DBIT    = 8;
  localparam int NB_OP   = 6;
  localparam int TO_W    = 8;
  localparam int TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             rx_done_tick = 1'b0;
  logic [DBIT-1:0]  rx_data = '0;
  logic             tx_done_tick = 1'b0;
  logic [DBIT-1:0]  alu_result;
  logic [DBIT-1:0]  alu_a, alu_b, tx_data;
  logic [NB_OP-1:0] alu_op;
  logic             tx_start, busy, err_timeout;
  logic [2:0]       dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int err_exp  = 0;
  int err_seen = 0;
  logic [31:0] exp_q[$];

  uart_alu_ctrl #(
    .DBIT(DBIT), .NB_OP(NB_OP), .TO_W(TO_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .tx_done_tick (tx_done_tick),
    .alu_result   (alu_result),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .busy         (busy),
    .err_timeout  (err_timeout),
    .dbg_state    (dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  // Stand-in combinational ALU
  always_comb begin
    case (alu_op)
      6'h20:   alu_result = alu_a + alu_b;
      6'h22:   alu_result = alu_a - alu_b;
      6'h23:   alu_result = ~(alu_a | alu_b);
      6'h24:   alu_result = alu_a & alu_b;
      default: alu_result = 8'h00;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: act=0x%0h req=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor: compares every tx_start against the expected queue
  logic prev_start = 1'b0;
  always @(negedge clk) begin
    if (tx_start) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_tx_start", 32'd1, 32'd0);
      end else begin
        chk("frame", {alu_a, alu_b, 2'b00, alu_op, tx_data}, exp_q.pop_front());
      end
      if (prev_start) chk("tx_start_width", 32'd2, 32'd1);
    end
    if (err_timeout) err_seen++;
    prev_start <= tx_start;
  end

  // Driver tasks: inputs change 1 time unit after the rising edge
  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done_tick = 1'b1;
    #1;
    chk("no_err_with_rx", {31'd0, err_timeout}, 32'd0);
    @(posedge clk); #1;
    rx_done_tick = 1'b0;
  endtask

  task automatic pulse_tx_done;
    tx_done_tick = 1'b1;
    @(posedge clk); #1;
    tx_done_tick = 1'b0;
  endtask

  task automatic push_exp(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] op, input logic [7:0] res);
    exp_q.push_back({a, b, op, res});
  endtask

  // Sends the opcode and follows the EXEC/SEND/WAIT_TX pipeline
  task automatic finish_frame(input logic [7:0] op_byte, input logic [7:0] exp_op,
                              input logic [7:0] exp_res, input bit drop);
    send_byte(op_byte);
    chk("op_latched", {26'd0, alu_op}, {24'd0, exp_op});
    chk("exec_state", {29'd0, dbg_state}, 32'd3);
    chk("start_not_early", {31'd0, tx_start}, 32'd0);
    tick();
    chk("start_n2", {31'd0, tx_start}, 32'd1);
    chk("tx_data_n2", {24'd0, tx_data}, {24'd0, exp_res});
    tick();
    chk("start_dropped", {31'd0, tx_start}, 32'd0);
    chk("busy_wait_tx", {31'd0, busy}, 32'd1);
    if (drop) begin
      send_byte(8'h99);
      chk("drop_state", {29'd0, dbg_state}, 32'd5);
    end
    tick();
    pulse_tx_done();
    chk("busy_after_done", {31'd0, busy}, 32'd0);
  endtask

  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op_byte,
                           input logic [7:0] exp_op, input logic [7:0] exp_res, input bit drop);
    push_exp(a, b, exp_op, exp_res);
    send_byte(a);
    send_byte(b);
    chk("a_latched", {24'd0, alu_a}, {24'd0, a});
    chk("b_latched", {24'd0, alu_b}, {24'd0, b});
    finish_frame(op_byte, exp_op, exp_res, drop);
  endtask

  // Waits out a timeout starting from the first cycle after the last byte
  task automatic expect_timeout;
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      chk("no_early_err", {31'd0, err_timeout}, 32'd0);
      tick();
    end
    chk("err_pulse", {31'd0, err_timeout}, 32'd1);
    err_exp++;
    tick();
    chk("err_cleared", {31'd0, err_timeout}, 32'd0);
    chk("idle_after_err", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_alu_a"},  {24'd0, alu_a}, 32'd0);
    chk({tag, "_alu_b"},  {24'd0, alu_b}, 32'd0);
    chk({tag, "_alu_op"}, {26'd0, alu_op}, 32'd0);
    chk({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
    chk({tag, "_tx_start"}, {31'd0, tx_start}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_err"}, {31'd0, err_timeout}, 32'd0);
  endtask

  initial begin
    #12;
    check_all_zero("reset");
    tick();
    reset = 1'b0;
    tick();

    // Normal frame and opcode masking
    run_frame(8'h12, 8'h34, 8'h20, 8'h20, 8'h46, 1'b0);
    run_frame(8'h0C, 8'h30, 8'hE3, 8'h23, 8'hC3, 1'b0);

    // tx_done outside WAIT_TX is ignored
    pulse_tx_done();
    chk("tx_done_ignored", {29'd0, dbg_state}, 32'd0);

    // Timeout in WAIT_B, then a clean frame
    send_byte(8'h55);
    expect_timeout();
    run_frame(8'h01, 8'h02, 8'h20, 8'h20, 8'h03, 1'b0);

    // Timeout in WAIT_OP
    send_byte(8'h66);
    send_byte(8'h77);
    expect_timeout();

    // Byte on the terminal-count cycle wins
    push_exp(8'h07, 8'h08, 8'h20, 8'h0F);
    send_byte(8'h07);
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    send_byte(8'h08);
    chk("race_state", {29'd0, dbg_state}, 32'd2);
    chk("race_b", {24'd0, alu_b}, 32'h08);
    finish_frame(8'h20, 8'h20, 8'h0F, 1'b0);

    // Byte dropped during WAIT_TX; next A comes from the following byte
    run_frame(8'h50, 8'h10, 8'h22, 8'h22, 8'h40, 1'b1);
    run_frame(8'h0A, 8'h05, 8'h22, 8'h22, 8'h05, 1'b0);

    // Asynchronous reset in WAIT_OP
    send_byte(8'h11);
    send_byte(8'h22);
    chk("pre_reset_state", {29'd0, dbg_state}, 32'd2);
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    chk("midreset_state", {29'd0, dbg_state}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    run_frame(8'h3C, 8'h0F, 8'h24, 8'h24, 8'h0C, 1'b0);

    repeat (4) tick();
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    chk("err_pulse_count", err_seen, err_exp);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
